bus_arbiter_wb8: RTL and testbench
==================================

# bus_arbiter_wb8

Two-master arbiter for the 8-bit Wishbone system bus. It shares the single slave-side bus, which feeds the existing address decoder for RAM, UART, SPI and LEDs, between master 0 (CPU) and master 1 (DMA/debug master). Grants are round-robin and locked for the whole `CYC` cycle. A bus watchdog completes any strobe that no slave acknowledges, so a mis-decoded address cannot hang a master.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: unacknowledged strobe cycles before a forced ACK; legal range 1..255.
- `TIMEOUT_DATA`, default 8'hFF: read data returned on a forced ACK.

Ports:
- `CLK_I` in 1: system clock; single clock domain.
- `RST_I` in 1: synchronous, active-high reset.
- `M0_CYC_I`, `M0_STB_I`, `M0_WE_I` in 1 each: master 0 bus cycle, strobe, write enable.
- `M0_ADR_I` in 32, `M0_DAT_I` in 8: master 0 address and write data.
- `M0_DAT_O` out 8, `M0_ACK_O` out 1: master 0 read data and acknowledge.
- `M1_*`: same six signals for master 1.
- `S_CYC_O`, `S_STB_O`, `S_WE_O` out 1 each: to the address decoder and slaves.
- `S_ADR_O` out 32, `S_DAT_O` out 8: slave-side address and write data.
- `S_DAT_I` in 8, `S_ACK_I` in 1: muxed slave read data and acknowledge.
- `O_owner` out 2: 2'b00 idle, 2'b01 master 0, 2'b10 master 1.
- `O_timeout` out 1: high during a forced-ACK cycle.

## Operation
- State register values: `IDLE`, `GRANT0`, `GRANT1`. A `last` register holds the last granted master.
- Transitions from `IDLE`:
  - only M0_CYC_I high → `GRANT0`.
  - only M1_CYC_I high → `GRANT1`.
  - both high → the master ≠ `last`.
  - `last` is updated on every grant.
- Transitions from `GRANTn`:
  - stay while Mn_CYC_I is high (locked; the other master waits).
  - Mn_CYC_I low and other master's CYC high → `GRANTother`, with no idle cycle between.
  - Mn_CYC_I low and other master's CYC low → `IDLE`.
- Outputs in `GRANTn`:
  - slave outputs are a combinational copy of master n: `S_CYC_O`, `S_STB_O`, `S_WE_O`, `S_ADR_O`, `S_DAT_O`.
  - Mn_ACK_O = S_ACK_I | forced_ack; Mn_DAT_O = forced_ack ? TIMEOUT_DATA : S_DAT_I.
  - the non-granted master sees ACK 0 and DAT 8'h00.
- Outputs in `IDLE`: all slave outputs 0, both ACKs 0.
- Watchdog:
  - 8-bit counter `wcnt`.
  - increments each cycle the granted master has STB high and S_ACK_I low.
  - clears on S_ACK_I, on forced_ack, and on any state change.
  - forced_ack = granted STB high & !S_ACK_I & (wcnt == TIMEOUT_CYCLES).
  - while forced_ack is high, `S_STB_O` is masked to 0; `O_timeout` = forced_ack.
  - a real S_ACK_I in the same cycle wins: no timeout, slave data passed through.
- Masters that drop STB without dropping CYC keep the grant; the counter holds its value while STB is low.

## Timing
- Reset values (held at the first edge with RST_I high):
  - state `IDLE`, `last` = 1 (so master 0 wins the first tie), `wcnt` = 0.
  - `O_owner` = 0.
  - all S_* outputs 0, both ACKs 0, both DATs 0, `O_timeout` 0.
- RST_I mid-transfer: the next state is `IDLE` unconditionally and the counter clears. No ACK is issued in the cycle after reset.
- Grant latency: CYC seen high at edge k, grant effective after edge k (registered). The slave sees the strobe in the cycle following the request, so there is 1 cycle of arbitration latency.
- Data path: zero added latency. ACK and data pass combinationally in the same cycle as the slave drives them.
- Handover: the other master's first strobe reaches the slave 1 cycle after the owner drops CYC.
- Forced ACK: with STB held and no slave ACK, ACK arrives in the (TIMEOUT_CYCLES+1)th strobe cycle and lasts exactly 1 cycle.
- Back-to-back strobes within one CYC are passed through unthrottled.

## Test plan
- Reset, then M0 reads RAM address 0x00000010 (slave ACK after 1 cycle) → S_CYC_O rises 1 cycle after M0_CYC_I; M0_DAT_O equals the slave byte; `O_owner` = 01; M1_ACK_O stays 0.
- Both CYC raised in the same cycle from reset → M0 granted first. M0 drops CYC → M1 granted at the next edge with no IDLE cycle. Next simultaneous request → M1 loses, M0 granted.
- M1 holds CYC across 4 strobes while M0 requests → M0 gets no ACK and `O_owner` stays 10 until M1 releases.
- M0 strobes address 0xE0000000 with no slave ACK, TIMEOUT_CYCLES=8 → M0_ACK_O high in the 9th strobe cycle with data 8'hFF; `O_timeout` pulses 1 cycle; S_STB_O low that cycle.
- Slave ACKs in the same cycle as wcnt==TIMEOUT_CYCLES → real data returned; `O_timeout` stays 0.
- RST_I asserted for 1 cycle while `GRANT1` has a pending strobe → `O_owner` = 00, S_CYC_O = 0, no ACK; arbitration resumes with M0 priority.

Source files
------------

// File: rtl/bus_arbiter_wb8.sv
// Two-master arbiter for the 8-bit Wishbone system bus: round-robin grants held for
// the whole CYC, plus a strobe watchdog that completes accesses no slave acknowledges.
module bus_arbiter_wb8 #(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
  input  logic        CLK_I,
  input  logic        RST_I,

  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,

  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,

  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [7:0]  S_DAT_O,
  input  logic [7:0]  S_DAT_I,
  input  logic        S_ACK_I,

  output logic [1:0]  O_owner,
  output logic        O_timeout
);

  // state  | meaning
  // IDLE   | no owner; slave side and both ACKs driven low
  // GRANT0 | master 0 (CPU) owns the bus until it drops CYC
  // GRANT1 | master 1 (DMA/debug) owns the bus until it drops CYC
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  state_t     state;
  state_t     state_nxt;
  logic       last;
  logic [7:0] wcnt;
  logic       grant_stb;
  logic       forced_ack;

  // The next owner is decided here so the counter can clear on any change of owner.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I)
          state_nxt = last ? GRANT0 : GRANT1;
        else if (M0_CYC_I)
          state_nxt = GRANT0;
        else if (M1_CYC_I)
          state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!M0_CYC_I)
          state_nxt = M1_CYC_I ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (!M1_CYC_I)
          state_nxt = M0_CYC_I ? GRANT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_stb  = ((state == GRANT0) && M0_STB_I) || ((state == GRANT1) && M1_STB_I);
  assign forced_ack = grant_stb && !S_ACK_I && (wcnt == TIMEOUT_CNT);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      last  <= 1'b1;
      wcnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt == GRANT0)
        last <= 1'b0;
      else if (state_nxt != state && state_nxt == GRANT1)
        last <= 1'b1;

      if (state_nxt != state || S_ACK_I || forced_ack)
        wcnt <= 8'd0;
      else if (grant_stb)
        wcnt <= wcnt + 8'd1;
    end
  end

  assign O_owner   = state;
  assign O_timeout = forced_ack;

  // A real slave ACK in the watchdog's cycle suppresses forced_ack, so slave data wins.
  always_comb begin
    S_CYC_O  = 1'b0;
    S_STB_O  = 1'b0;
    S_WE_O   = 1'b0;
    S_ADR_O  = 32'd0;
    S_DAT_O  = 8'd0;
    M0_ACK_O = 1'b0;
    M0_DAT_O = 8'd0;
    M1_ACK_O = 1'b0;
    M1_DAT_O = 8'd0;
    case (state)
      GRANT0: begin
        S_CYC_O  = M0_CYC_I;
        S_STB_O  = M0_STB_I && !forced_ack;
        S_WE_O   = M0_WE_I;
        S_ADR_O  = M0_ADR_I;
        S_DAT_O  = M0_DAT_I;
        M0_ACK_O = S_ACK_I || forced_ack;
        M0_DAT_O = forced_ack ? TIMEOUT_DATA : S_DAT_I;
      end
      GRANT1: begin
        S_CYC_O  = M1_CYC_I;
        S_STB_O  = M1_STB_I && !forced_ack;
        S_WE_O   = M1_WE_I;
        S_ADR_O  = M1_ADR_I;
        S_DAT_O  = M1_DAT_I;
        M1_ACK_O = S_ACK_I || forced_ack;
        M1_DAT_O = forced_ack ? TIMEOUT_DATA : S_DAT_I;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_wb8.sv
// Bench for bus_arbiter_wb8: two Wishbone master drivers, a latency-per-region slave,
// and a negedge monitor that scores ACKs, data, ownership and watchdog behaviour.
module tb_bus_arbiter_wb8;
  localparam int         TO      = 8;
  localparam logic [7:0] TO_DATA = 8'hFF;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         cycles;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [7:0]  m_wdat[2];
  logic        m0_ack, m1_ack;
  logic [7:0]  m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr;
  logic [7:0]  s_wdat, s_rdat;
  logic [1:0]  owner;
  logic        timeout;

  bus_arbiter_wb8 #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TO_DATA)) dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]), .M0_ADR_I(m_adr[0]),
    .M0_DAT_I(m_wdat[0]), .M0_DAT_O(m0_rdat), .M0_ACK_O(m0_ack),
    .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]), .M1_ADR_I(m_adr[1]),
    .M1_DAT_I(m_wdat[1]), .M1_DAT_O(m1_rdat), .M1_ACK_O(m1_ack),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we), .S_ADR_O(s_adr), .S_DAT_O(s_wdat),
    .S_DAT_I(s_rdat), .S_ACK_I(s_ack),
    .O_owner(owner), .O_timeout(timeout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave map by top nibble: ACK latency in strobe cycles, -1 means nothing decodes.
  function automatic int lat_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'h1:    return 1;
      4'h2:    return 3;
      4'h3:    return TO;
      4'h4:    return TO + 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] rd_of(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'hA5;
  endfunction

  // Slave presence uses the master strobes directly to avoid a loop through the STB mask.
  logic present;
  int   sl_cnt;
  assign present = s_cyc && ((owner == 2'b01 && m_stb[0]) || (owner == 2'b10 && m_stb[1]));
  assign s_ack   = present && (lat_of(s_adr) >= 0) && (sl_cnt == lat_of(s_adr));
  assign s_rdat  = rd_of(s_adr);

  always @(posedge clk) begin
    if (rst || !present || m0_ack || m1_ack) sl_cnt <= 0;
    else                                     sl_cnt <= sl_cnt + 1;
  end

  // Ownership reference: owner keeps the bus while its CYC is high, otherwise the
  // requester that was not granted last wins.
  logic [1:0] exp_owner;
  logic       exp_last;
  int         w;
  always @(posedge clk) begin
    if (rst) begin
      exp_owner <= 2'b00;
      exp_last  <= 1'b1;
    end else if (!(exp_owner == 2'b01 && m_cyc[0]) && !(exp_owner == 2'b10 && m_cyc[1])) begin
      w = -1;
      if (m_cyc[0] && m_cyc[1]) w = exp_last ? 0 : 1;
      else if (m_cyc[0])        w = 0;
      else if (m_cyc[1])        w = 1;
      if (w < 0) exp_owner <= 2'b00;
      else begin
        exp_owner <= 2'(w + 1);
        exp_last  <= (w == 1);
      end
    end
  end

  exp_t q0[$];
  exp_t q1[$];
  int   cnt[2];
  logic mon_en = 1'b0;

  logic       granted, strobe, e_ack, e_to, act_ack, has, exp_to_any;
  logic [7:0] act_dat;
  int         c;
  exp_t       h;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_to_any = 1'b0;
      chk("owner", 32'(owner), 32'(exp_owner));
      for (int i = 0; i < 2; i++) begin
        granted = (exp_owner == 2'(i + 1));
        act_ack = (i == 0) ? m0_ack : m1_ack;
        act_dat = (i == 0) ? m0_rdat : m1_rdat;
        strobe  = granted && m_stb[i];
        e_ack   = 1'b0;
        e_to    = 1'b0;
        c       = cnt[i] + 1;
        has     = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (has) begin
          if (i == 0) h = q0[0];
          else        h = q1[0];
        end
        if (strobe && has && c == h.cycles) begin
          e_ack = 1'b1;
          e_to  = h.to;
        end
        chk($sformatf("m%0d_ack", i), 32'(act_ack), 32'(e_ack));
        if (act_ack && e_ack) chk($sformatf("m%0d_dat", i), 32'(act_dat), 32'(h.data));
        if (!granted) chk($sformatf("m%0d_dat_ungranted", i), 32'(act_dat), 32'd0);
        if (act_ack && has) begin
          if (i == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          cnt[i] = 0;
        end else if (strobe) begin
          cnt[i] = c;
        end
        if (granted) begin
          exp_to_any = e_to;
          chk("s_cyc", 32'(s_cyc), 32'(m_cyc[i]));
          chk("s_stb", 32'(s_stb), 32'(m_stb[i] && !e_to));
          chk("s_we",  32'(s_we),  32'(m_we[i]));
          chk("s_adr", s_adr, m_adr[i]);
          chk("s_dat", 32'(s_wdat), 32'(m_wdat[i]));
        end
      end
      chk("timeout", 32'(timeout), 32'(exp_to_any));
      if (exp_owner == 2'b00) begin
        chk("s_cyc_idle", 32'(s_cyc), 32'd0);
        chk("s_stb_idle", 32'(s_stb), 32'd0);
      end
      if (rst) begin
        cnt[0] = 0;
        cnt[1] = 0;
      end
    end
  end

  task automatic xfer(input int id, input logic [31:0] a);
    exp_t e;
    int   l;
    int   waited;
    l        = lat_of(a);
    e.to     = (l < 0) || (l > TO);
    e.cycles = e.to ? TO + 1 : l + 1;
    e.data   = e.to ? TO_DATA : rd_of(a);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    m_stb[id]  = 1'b1;
    m_adr[id]  = a;
    m_we[id]   = 1'($urandom);
    m_wdat[id] = 8'($urandom);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!((id == 0) ? m0_ack : m1_ack) && waited < 400);
    if (waited >= 400)
      chk($sformatf("m%0d_ack_wait", id), 32'((id == 0) ? m0_ack : m1_ack), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic one_txn(input int id, input logic [31:0] a);
    m_cyc[id] = 1'b1;
    xfer(id, a);
    m_stb[id] = 1'b0;
    m_cyc[id] = 1'b0;
  endtask

  task automatic burst(input int id);
    logic [3:0] tops[6];
    int n;
    tops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hE};
    n = $urandom_range(1, 4);
    m_cyc[id] = 1'b1;
    for (int k = 0; k < n; k++) begin
      xfer(id, {tops[$urandom_range(0, 5)], 20'h0, 8'($urandom)});
      if (k < n - 1 && $urandom_range(0, 2) == 0) begin
        m_stb[id] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    m_stb[id] = 1'b0;
    m_cyc[id] = 1'b0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_adr[i] = 32'd0; m_wdat[i] = 8'd0;
      cnt[i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_owner",   32'(owner),   32'd0);
    chk("rst_s_cyc",   32'(s_cyc),   32'd0);
    chk("rst_s_stb",   32'(s_stb),   32'd0);
    chk("rst_s_we",    32'(s_we),    32'd0);
    chk("rst_s_adr",   s_adr,        32'd0);
    chk("rst_s_dat",   32'(s_wdat),  32'd0);
    chk("rst_m0_ack",  32'(m0_ack),  32'd0);
    chk("rst_m1_ack",  32'(m1_ack),  32'd0);
    chk("rst_m0_dat",  32'(m0_rdat), 32'd0);
    chk("rst_m1_dat",  32'(m1_rdat), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // simultaneous requests from reset, then again after the handover
    fork
      one_txn(0, 32'h0000_0011);
      one_txn(1, 32'h1000_0022);
    join
    fork
      one_txn(0, 32'h2000_0033);
      one_txn(1, 32'h0000_0044);
    join
    repeat (2) @(posedge clk);
    #1;

    one_txn(0, 32'h1000_0010);

    // master 1 keeps CYC across four strobes while master 0 waits
    fork
      begin
        m_cyc[1] = 1'b1;
        for (int k = 0; k < 4; k++) xfer(1, 32'h1000_0000 | 32'(k));
        m_stb[1] = 1'b0;
        m_cyc[1] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        one_txn(0, 32'h0000_0020);
      end
    join

    one_txn(0, 32'hE000_0000);
    one_txn(0, 32'h3000_0042);
    one_txn(1, 32'h4000_0055);

    fork
      repeat (20) burst(0);
      repeat (20) burst(1);
    join

    // reset while master 1 has an unacknowledged strobe pending
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'hE000_0000; m_we[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_owner", 32'(owner), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    m_cyc[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_stb[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_owner", 32'(owner),  32'd0);
    chk("post_rst_s_cyc", 32'(s_cyc),  32'd0);
    chk("post_rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("post_rst_m1_ack", 32'(m1_ack), 32'd0);
    @(negedge clk);
    chk("post_rst_tie_owner", 32'(owner), 32'd1);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;
    m_cyc[1] = 1'b0;
    @(posedge clk); #1;
    one_txn(0, 32'h1000_0001);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
